// File: rtl/irq_ctrl.sv
// Peripheral-side interrupt controller feeding the coprocessor's interrupt lines.
// Synchronizes raw requests, latches them per source as edge or level, masks, and snapshots on exl rise.
module irq_ctrl #(
    parameter int NSRC        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   irq_in,
    input  logic              we,
    input  logic              re,
    input  logic [1:0]        addr,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    input  logic              exl,
    output logic [NSRC-1:0]   interrupt,
    output logic              irq_any
);

    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_MODE = 2'd2;
    localparam logic [1:0] ADDR_SNAP = 2'd3;

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q, sync_d;
    logic [NSRC-1:0] hist_q, hist_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] snap_q, snap_d;
    logic [NSRC-1:0] interrupt_q, interrupt_d;
    logic            irq_any_q, irq_any_d;
    logic            exl_q, exl_d;

    logic [NSRC-1:0] sync_out;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] masked;
    logic            unused_wd;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign rise      = sync_out & ~hist_q;
    assign masked    = pend_q & mask_q;
    assign unused_wd = ^wd[31:NSRC];

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        hist_d = sync_out;
        w1c    = (we && addr == ADDR_PEND) ? wd[NSRC-1:0] : '0;
        pend_d = pend_q;
        // Edge bits: a fresh edge beats a simultaneous W1C. Level bits track the synchronizer.
        for (int i = 0; i < NSRC; i++) begin
            if (mode_q[i]) begin
                pend_d[i] = (pend_q[i] & ~w1c[i]) | rise[i];
            end else begin
                pend_d[i] = sync_out[i];
            end
        end
    end

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (we && addr == ADDR_MASK) begin
            mask_d = wd[NSRC-1:0];
        end
        if (we && addr == ADDR_MODE) begin
            mode_d = wd[NSRC-1:0];
        end
    end

    always_comb begin
        exl_d  = exl;
        snap_d = snap_q;
        if (exl && !exl_q) begin
            snap_d = masked;
        end
        interrupt_d = masked;
        irq_any_d   = |masked;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            hist_q      <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            mode_q      <= '0;
            snap_q      <= '0;
            interrupt_q <= '0;
            irq_any_q   <= 1'b0;
            exl_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            snap_q      <= snap_d;
            interrupt_q <= interrupt_d;
            irq_any_q   <= irq_any_d;
            exl_q       <= exl_d;
        end
    end

    always_comb begin
        rd = 32'h0;
        if (re) begin
            unique case (addr)
                ADDR_PEND: rd = {{(32-NSRC){1'b0}}, pend_q};
                ADDR_MASK: rd = {{(32-NSRC){1'b0}}, mask_q};
                ADDR_MODE: rd = {{(32-NSRC){1'b0}}, mode_q};
                ADDR_SNAP: rd = {{(32-NSRC){1'b0}}, snap_q};
                default:   rd = 32'h0;
            endcase
        end
    end

    assign interrupt = interrupt_q;
    assign irq_any   = irq_any_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed expectations with SYNC_STAGES=2.
// Inputs change 1ns after a rising edge; outputs are checked in the same window.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  irq_in = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        exl = 1'b0;
    logic [5:0]  interrupt;
    logic        irq_any;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.NSRC(6), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .we        (we),
        .re        (re),
        .addr      (addr),
        .wd        (wd),
        .rd        (rd),
        .exl       (exl),
        .interrupt (interrupt),
        .irq_any   (irq_any)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        re   = 1'b1;
        addr = a;
        #1;
        chk(tag, rd, exp);
        re   = 1'b0;
        addr = 2'd0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
        tick();
        we   = 1'b0;
        addr = 2'd0;
        wd   = '0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_int", {26'h0, interrupt}, 32'h0);
        chk("rst_any", {31'h0, irq_any}, 32'h0);
        rchk("rst_pend", 2'd0, 32'h0);
        rchk("rst_mask", 2'd1, 32'h0);
        rchk("rst_mode", 2'd2, 32'h0);
        rchk("rst_snap", 2'd3, 32'h0);
        re = 1'b0;
        addr = 2'd2;
        #1;
        chk("rd_no_re", rd, 32'h0);
        addr = 2'd0;
        tick(2);
        rst = 1'b1;
        tick(2);

        // Edge latch and W1C on source 0
        wr(2'd2, 32'h3F);
        wr(2'd1, 32'h01);
        irq_in = 6'h01;
        tick(3);
        rchk("edge_pend", 2'd0, 32'h01);
        chk("edge_int_early", {26'h0, interrupt}, 32'h0);
        irq_in = 6'h00;
        tick();
        chk("edge_int", {26'h0, interrupt}, 32'h01);
        chk("edge_any", {31'h0, irq_any}, 32'h1);
        tick(4);
        chk("edge_hold", {26'h0, interrupt}, 32'h01);
        rchk("edge_pend_hold", 2'd0, 32'h01);
        wr(2'd0, 32'h1);
        rchk("w1c_pend", 2'd0, 32'h0);
        chk("w1c_int_lag", {26'h0, interrupt}, 32'h01);
        tick();
        chk("w1c_int", {26'h0, interrupt}, 32'h0);
        chk("w1c_any", {31'h0, irq_any}, 32'h0);

        // Masking: sources 4 and 5 pend with mask closed
        wr(2'd1, 32'h00);
        irq_in = 6'h30;
        tick(3);
        irq_in = 6'h00;
        tick(3);
        rchk("mask_pend", 2'd0, 32'h30);
        chk("mask_int0", {26'h0, interrupt}, 32'h0);
        chk("mask_any0", {31'h0, irq_any}, 32'h0);
        wr(2'd1, 32'h20);
        chk("mask_int_lag", {26'h0, interrupt}, 32'h0);
        tick();
        chk("mask_int", {26'h0, interrupt}, 32'h20);
        chk("mask_any", {31'h0, irq_any}, 32'h1);
        wr(2'd0, 32'h3F);
        rchk("mask_clr", 2'd0, 32'h0);
        tick(2);

        // SNAP capture on exl rise
        wr(2'd1, 32'h13);
        irq_in = 6'h12;
        tick(3);
        irq_in = 6'h00;
        tick(3);
        rchk("snap_pre_pend", 2'd0, 32'h12);
        exl = 1'b1;
        tick();
        rchk("snap_12", 2'd3, 32'h12);
        wr(2'd0, 32'h12);
        irq_in = 6'h01;
        tick(3);
        irq_in = 6'h00;
        tick(3);
        rchk("snap_pend01", 2'd0, 32'h01);
        rchk("snap_held", 2'd3, 32'h12);
        exl = 1'b0;
        tick();
        exl = 1'b1;
        tick();
        rchk("snap_01", 2'd3, 32'h01);
        wr(2'd3, 32'hFF);
        rchk("snap_ro", 2'd3, 32'h01);
        exl = 1'b0;
        wr(2'd0, 32'h3F);
        tick(2);

        // Set-over-clear on source 1: edge detected on the W1C clock
        irq_in = 6'h02;
        tick(2);
        wr(2'd0, 32'h02);
        rchk("set_wins", 2'd0, 32'h02);
        wr(2'd0, 32'h02);
        rchk("clr_no_edge", 2'd0, 32'h00);
        irq_in = 6'h00;
        tick(3);

        // Level mode on source 2
        wr(2'd2, 32'h00);
        wr(2'd1, 32'h04);
        irq_in = 6'h04;
        tick(3);
        chk("lvl_int_early", {26'h0, interrupt}, 32'h0);
        tick();
        chk("lvl_int_rise", {26'h0, interrupt}, 32'h04);
        wr(2'd0, 32'h04);
        rchk("lvl_w1c_ignored", 2'd0, 32'h04);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lvl_int_held", {26'h0, interrupt}, 32'h04);
        end
        irq_in = 6'h00;
        tick(3);
        chk("lvl_int_lag", {26'h0, interrupt}, 32'h04);
        rchk("lvl_pend_fall", 2'd0, 32'h00);
        tick();
        chk("lvl_int_fall", {26'h0, interrupt}, 32'h0);
        chk("lvl_any_fall", {31'h0, irq_any}, 32'h0);

        // Asynchronous reset mid-activity with everything pending and enabled
        wr(2'd2, 32'h3F);
        wr(2'd1, 32'h3F);
        irq_in = 6'h3F;
        tick(4);
        chk("pre_rst_int", {26'h0, interrupt}, 32'h3F);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_int", {26'h0, interrupt}, 32'h0);
        chk("arst_any", {31'h0, irq_any}, 32'h0);
        rchk("arst_pend", 2'd0, 32'h0);
        rchk("arst_mask", 2'd1, 32'h0);
        rchk("arst_mode", 2'd2, 32'h0);
        irq_in = 6'h00;
        tick(2);
        rst = 1'b1;
        tick(2);
        wr(2'd2, 32'h08);
        irq_in = 6'h08;
        tick(3);
        rchk("repend", 2'd0, 32'h08);
        chk("repend_int", {26'h0, interrupt}, 32'h0);
        irq_in = 6'h00;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Peripheral-side interrupt controller: the source end of the CP0 6-line interrupt interface.
- Synchronizes up to six asynchronous peripheral requests and latches them as edge- or level-sensitive, per source.
- Applies a per-source mask and drives registered interrupt[5:0] into the coprocessor.
- Memory-mapped so handler code can inspect, acknowledge and configure sources; snapshots the request set when the coprocessor raises exl.

Parameters:
- NSRC, 6, number of interrupt sources (must match coprocessor interrupt width).
- SYNC_STAGES, 2, flip-flop stages per irq_in synchronizer (min 2).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous active-low reset.
- irq_in  input  NSRC  raw peripheral requests, asynchronous to clk.
- we  input  1  register write strobe.
- re  input  1  register read enable.
- addr  input  2  register select.
- wd  input  32  write data.
- rd  output  32  read data.
- exl  input  1  exception-level flag from coprocessor.
- interrupt  output  NSRC  masked requests to coprocessor, registered.
- irq_any  output  1  OR of interrupt, registered.

Behaviour:
- Reset (rst=0, asynchronous): synchronizers, edge-history, PEND, MASK, MODE, SNAP, interrupt and irq_any all go to 0. Takes effect immediately, mid-transfer included; the first edge after release starts from a clean state.
- Synchronizer: irq_in[i] passes SYNC_STAGES flops to give s[i]. A history flop h[i] holds the previous s[i].
- Edge mode, MODE[i]=1:
  - PEND[i] sets on the clock where s[i]=1 and h[i]=0.
  - PEND[i] stays set until cleared by a write-1 to PEND.
- Level mode, MODE[i]=0:
  - PEND[i] <= s[i] every clock.
  - Writes to PEND[i] have no effect.
- Output: interrupt <= PEND & MASK and irq_any <= |(PEND & MASK), both registered one clock after PEND/MASK update.
- Latency, edge mode: irq_in rising seen at sampling edge k gives PEND set at edge k+SYNC_STAGES and interrupt high at edge k+SYNC_STAGES+1.
- Register map (bits above NSRC read 0):
  - addr 0 PEND: read = PEND. Write = W1C on edge-mode bits.
  - addr 1 MASK: read/write.
  - addr 2 MODE: read/write.
  - addr 3 SNAP: read-only, writes ignored.
- SNAP capture: on the clock where exl=1 and the previous exl sample was 0, SNAP <= PEND & MASK. SNAP holds until the next exl rising.
- rd: combinational. rd = selected register when re=1, else 32'h0.
- Simultaneous events:
  - W1C and new detected edge on the same bit, same clock: set wins, PEND stays 1.
  - MASK write and PEND change, same clock: interrupt next clock uses the new values of both.
  - MODE switch edge→level: PEND follows s[i] from the next clock. Switch level→edge: the current PEND is retained, new edges are detected from h.
  - Write to MODE/MASK while exl=1: permitted. interrupt still updates; gating is the coprocessor's job.
- Short pulses: an irq_in pulse shorter than one clk period may be missed. Peripherals must hold requests ≥2 clk periods.
- No internal state machine beyond the per-bit pend/edge logic and exl edge detect. Size is roughly 150–250 lines of RTL.

Test Plan:
- Reset: drive rst=0 mid-activity with PEND=6'h3F, MASK=6'h3F → interrupt=0, irq_any=0, all registers read 0 immediately; after release, the next irq_in edge re-pends.
- Edge latch and W1C:
  - Setup: MODE=6'h3F, MASK=6'h01, pulse irq_in[0] for 3 clocks.
  - Expect: PEND=6'h01 and interrupt=6'h01 at the computed latency, held after irq_in drops.
  - Write PEND=32'h1: interrupt returns to 0 one clock later.
- Level mode: MODE=0, MASK=6'h04, hold irq_in[2]=1 for 10 clocks → interrupt[2]=1 throughout (after latency), drops SYNC_STAGES+1 clocks after release. A W1C write to bit 2 while held has no effect.
- Masking: PEND=6'h30 (edges on sources 4,5), MASK=0 → interrupt=0, irq_any=0. Write MASK=6'h20 → interrupt=6'h20, irq_any=1 next clock.
- Set-over-clear: a detected edge on source 1 on the same clock as a W1C write of bit 1 → PEND[1]=1 after that clock.
- SNAP: with PEND&MASK=6'h12, raise exl → SNAP reads 32'h12. Change PEND to 6'h01 while exl stays high → SNAP still 32'h12. Drop and re-raise exl → SNAP=32'h01.
